inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit that drives the combinational instruction ROM read port and feeds fetched instructions to decode through a 2-entry buffer with a valid/ready handshake. It holds the PC, issues one word-aligned ROM read per cycle when buffer space allows, and accepts PC redirects from the execute/branch stage. It sits between the instruction ROM and the decode stage of the core.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset
- ADDR_WIDTH, 12, ROM word-address bits; valid byte range is 0 .. 4*2^ADDR_WIDTH-1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rom_addr  out  32  byte address to ROM; always equals current PC (combinational from PC register)
- rom_data  in  32  ROM word for rom_addr, valid in the same cycle
- redirect_valid  in  1  load new PC this cycle
- redirect_pc  in  32  new PC value
- out_valid  out  1  buffer head holds an entry
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  32  PC of head entry
- out_inst  out  32  instruction of head entry
- out_fault  out  1  head entry is a fetch fault

## Operation
- State: pc (32), halted (1), 2-entry FIFO of {pc, inst, fault}, count (0..2).
- pop = out_valid & out_ready. fetch = !halted & !redirect_valid & (count<2 | pop).
- fault condition on current pc: pc[1:0]!=0, or pc[31:ADDR_WIDTH+2]!=0.
- On fetch without fault: push {pc, rom_data, 0}; pc <= pc+4 (mod 2^32).
- On fetch with fault: push {pc, 32'h0, 1}; pc unchanged; halted <= 1. No further fetches until redirect.
- On redirect_valid: FIFO flushed (count <= 0), pc <= redirect_pc, halted <= 0; no push that cycle. A handshake (pop) in the same cycle counts as accepted by decode; flush overrides it.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- count==2 and !pop: no fetch, pc holds, rom_addr stable.
- Entries are never dropped or reordered except by redirect flush or reset.
- out_pc/out_inst/out_fault show the head entry; when empty they show 0.

## Timing
- Reset (async assert, any time including mid-transfer): pc=RESET_PC, halted=0, count=0, out_valid=0, out_pc=0, out_inst=0, out_fault=0, rom_addr=RESET_PC.
- First rising edge after rst_n release fetches RESET_PC; out_valid=1 after that edge.
- Fetch-to-output latency: 1 edge. Steady throughput 1 instruction/cycle with out_ready held 1.
- Redirect sampled at edge N: rom_addr=redirect_pc after N; out_valid=0 after N; first new entry valid after edge N+1.
- out_valid/out_* are register outputs; no combinational path from out_ready or redirect_* to out_*.
- rom_addr depends only on the pc register.

## Test plan
- Reset stream: RESET_PC=0, ROM word k = 0x1000+k, out_ready=1 -> after edge 1 out_pc=0/out_inst=0x1000, then 4/0x1001, 8/0x1002 on consecutive cycles, out_fault=0.
- Backpressure: out_ready=0 for 5 cycles from reset -> count saturates at 2, rom_addr holds 0x8, head stays pc 0; release out_ready -> pcs 0,4,8,0xC in order, no gaps or duplicates.
- Redirect with full buffer: count=2, redirect_pc=0x40 (out_ready=1) -> next cycle out_valid=0, rom_addr=0x40; following cycle out_pc=0x40, out_inst=word 16.
- Misaligned redirect: redirect_pc=0x42 -> one entry out_pc=0x42, out_fault=1, out_inst=0; rom_addr stays 0x42, no more entries for 10 cycles; redirect to 0x0 resumes normal fetch.
- End of ROM (ADDR_WIDTH=12): redirect to 0x3FF8 -> entries 0x3FF8, 0x3FFC with fault=0, then 0x4000 with fault=1, then halt.
- Reset mid-operation: assert rst_n=0 asynchronously with count=2 -> out_valid=0 and rom_addr=RESET_PC immediately, before next clock edge; stream restarts from RESET_PC after release.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: holds the PC, reads the combinational instruction ROM
// once per cycle and hands {pc, inst, fault} entries to decode via a 2-entry FIFO.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  // Bits that may be set in a legal fetch address: word-aligned and inside the ROM.
  localparam logic [63:0] RANGE_MASK = (64'd1 << (ADDR_WIDTH + 2)) - 64'd1;
  localparam logic [31:0] VALID_MASK = RANGE_MASK[31:0] & ~32'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } entry_t;

  entry_t      entry_reg  [2];
  entry_t      entry_next [2];
  logic [1:0]  count_reg, count_next;
  logic [31:0] pc_reg, pc_next;
  logic        halted_reg, halted_next;

  logic        pop;
  logic        fetch;
  logic        fault;
  logic [1:0]  level;
  entry_t      new_entry;

  always_comb begin
    pop        = (count_reg != 2'd0) & out_ready;
    fetch      = !halted_reg & !redirect_valid & ((count_reg != 2'd2) | pop);
    fault      = |(pc_reg & ~VALID_MASK);
    new_entry.pc    = pc_reg;
    new_entry.inst  = fault ? 32'h0 : rom_data;
    new_entry.fault = fault;

    entry_next[0] = entry_reg[0];
    entry_next[1] = entry_reg[1];
    count_next    = count_reg;
    pc_next       = pc_reg;
    halted_next   = halted_reg;
    level         = count_reg;

    if (redirect_valid) begin
      entry_next[0] = '0;
      entry_next[1] = '0;
      count_next    = 2'd0;
      pc_next       = redirect_pc;
      halted_next   = 1'b0;
    end else begin
      // Slots past the fill level are kept at zero so an empty head reads as 0.
      if (pop) begin
        entry_next[0] = entry_reg[1];
        entry_next[1] = '0;
        level         = count_reg - 2'd1;
      end
      if (fetch) begin
        if (level == 2'd0) entry_next[0] = new_entry;
        else               entry_next[1] = new_entry;
        level = level + 2'd1;
        if (fault) halted_next = 1'b1;
        else       pc_next     = pc_reg + 32'd4;
      end
      count_next = level;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) entry_reg[i] <= '0;
      count_reg  <= 2'd0;
      pc_reg     <= RESET_PC;
      halted_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) entry_reg[i] <= entry_next[i];
      count_reg  <= count_next;
      pc_reg     <= pc_next;
      halted_reg <= halted_next;
    end
  end

  assign rom_addr  = pc_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_pc    = entry_reg[0].pc;
  assign out_inst  = entry_reg[0].inst;
  assign out_fault = entry_reg[0].fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic
// compared against a queue-based model of the fetch stream.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  int errors = 0;
  int checks = 0;

  inst_fetch #(.RESET_PC(32'h0), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000 + {20'h0, a[13:2]};
  endfunction

  assign rom_data = rom_word(rom_addr);

  // Reference model: next fetch address, halt flag and the queue decode sees.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  logic [31:0] m_pc;
  bit          m_halted;
  ent_t        m_q[$];

  task automatic model_reset();
    m_pc = 32'h0;
    m_halted = 0;
    m_q.delete();
  endtask

  task automatic tick();
    bit   pop;
    bit   fetch;
    bit   flt;
    ent_t e;
    pop = (m_q.size() > 0) && out_ready;
    if (pop)
      $display("txn pc=%08h inst=%08h fault=%0d", m_q[0].pc, m_q[0].inst, m_q[0].fault);
    if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc;
      m_halted = 0;
    end else begin
      fetch = !m_halted && (m_q.size() < 2 || pop);
      if (pop) void'(m_q.pop_front());
      if (fetch) begin
        flt = (m_pc[1:0] != 2'b00) || (m_pc >= 32'h4000);
        e.pc = m_pc;
        e.inst = flt ? 32'h0 : rom_word(m_pc);
        e.fault = flt;
        m_q.push_back(e);
        if (flt) m_halted = 1;
        else m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({out_valid, out_fault} !== 2'b00 || out_pc !== 32'h0 || out_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0d pc=%08h inst=%08h fault=%0d, need all 0",
               out_valid, out_pc, out_inst, out_fault);
    end
    checks++;
    if (rom_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_rom_addr: got %08h need 00000000", rom_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_inst !== 32'(32'h1000 + i) ||
          out_fault !== 1'b0) begin
        errors++;
        $display("FAIL stream_%0d: valid=%0d pc=%08h inst=%08h fault=%0d, need 1/%08h/%08h/0",
                 i, out_valid, out_pc, out_inst, out_fault, 4 * i, 32'h1000 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    repeat (5) tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || rom_addr !== 32'h8) begin
      errors++;
      $display("FAIL backpressure_hold: valid=%0d pc=%08h rom_addr=%08h, need 1/00000000/00000008",
               out_valid, out_pc, rom_addr);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * j)) begin
        errors++;
        $display("FAIL backpressure_order_%0d: valid=%0d pc=%08h, need 1/%08h",
                 j, out_valid, out_pc, 4 * j);
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    out_ready = 1'b0;
    repeat (2) tick();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 32'h40) begin
      errors++;
      $display("FAIL redirect_flush: valid=%0d rom_addr=%08h, need 0/00000040", out_valid, rom_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h1010 || out_fault !== 1'b0) begin
      errors++;
      $display("FAIL redirect_first: valid=%0d pc=%08h inst=%08h fault=%0d, need 1/00000040/00001010/0",
               out_valid, out_pc, out_inst, out_fault);
    end
  endtask

  task automatic test_misaligned();
    int bad;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h42 || out_inst !== 32'h0 || out_fault !== 1'b1 ||
        rom_addr !== 32'h42) begin
      errors++;
      $display("FAIL misaligned_entry: valid=%0d pc=%08h inst=%08h fault=%0d rom_addr=%08h, need 1/42/0/1/42",
               out_valid, out_pc, out_inst, out_fault, rom_addr);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid !== 1'b0 || rom_addr !== 32'h42) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL misaligned_halt: %0d of 10 cycles had valid or moved rom_addr, need 0", bad);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1000 || out_fault !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_resume: valid=%0d pc=%08h inst=%08h fault=%0d, need 1/0/00001000/0",
               out_valid, out_pc, out_inst, out_fault);
    end
  endtask

  task automatic test_end_of_rom();
    logic [31:0] exp_pc  [3];
    logic [31:0] exp_ins [3];
    logic        exp_flt [3];
    exp_pc = '{32'h3FF8, 32'h3FFC, 32'h4000};
    exp_ins = '{32'h1FFE, 32'h1FFF, 32'h0};
    exp_flt = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3FF8;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_inst !== exp_ins[i] ||
          out_fault !== exp_flt[i]) begin
        errors++;
        $display("FAIL end_of_rom_%0d: valid=%0d pc=%08h inst=%08h fault=%0d, need 1/%08h/%08h/%0d",
                 i, out_valid, out_pc, out_inst, out_fault, exp_pc[i], exp_ins[i], exp_flt[i]);
      end
    end
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 32'h4000) begin
      errors++;
      $display("FAIL end_of_rom_halt: valid=%0d rom_addr=%08h, need 0/00004000", out_valid, rom_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 32'h0 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_async: valid=%0d rom_addr=%08h pc=%08h, need 0/0/0",
               out_valid, rom_addr, out_pc);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1000) begin
      errors++;
      $display("FAIL reset_mid_restart: valid=%0d pc=%08h inst=%08h, need 1/0/00001000",
               out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_flt;
    logic        e_val;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
        1: redirect_pc = 32'h3FF0 + 32'(4 * $urandom_range(0, 3));
        2: redirect_pc = $urandom;
        default: redirect_pc = 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 1) * 2);
      endcase
      tick();
      e_val = (m_q.size() > 0);
      e_pc = e_val ? m_q[0].pc : 32'h0;
      e_inst = e_val ? m_q[0].inst : 32'h0;
      e_flt = e_val ? m_q[0].fault : 1'b0;
      checks++;
      if (out_valid !== e_val || out_pc !== e_pc || out_inst !== e_inst || out_fault !== e_flt ||
          rom_addr !== m_pc) begin
        errors++;
        $display("FAIL random_%0d: got v=%0d pc=%08h inst=%08h f=%0d ra=%08h, need v=%0d pc=%08h inst=%08h f=%0d ra=%08h",
                 n, out_valid, out_pc, out_inst, out_fault, rom_addr,
                 e_val, e_pc, e_inst, e_flt, m_pc);
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_end_of_rom();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
